register_sequencer: RTL and testbench
=====================================

// Module: register_sequencer
// PURPOSE
//  Control stage directly upstream of the X/Y/Z operand registers. Accepts one instruction
//  per valid/ready handshake and drives each register's 3-bit op code (Tx/Ty/Tz), the ULA
//  operation select and the X-input mux, for one or more cycles, then pulses done.
//  Turns the datapath's per-register op codes into sequenced instructions.
// PARAMETERS
//  OPW     3  width of the Tx/Ty/Tz register op codes (HOLD=000 LOAD=001 SHIFTR=010 SHIFTL=011 RESET=100)
//  SHAMTW  2  width of the shift-count field; max repeated shift = 2**SHAMTW-1
// PORTS
//  clk          in   1       rising-edge clock, the only clock
//  rst_n        in   1       reset, synchronous, active-low
//  instr        in   4       opcode; 0xxx legal, 1xxx illegal
//  shamt        in   SHAMTW  shift count for SHRX/SHLX; ignored for other opcodes
//  instr_valid  in   1       instr/shamt valid this cycle
//  ready        out  1       sequencer can accept; high only in IDLE
//  Tx, Ty, Tz   out  OPW     op codes to registers X, Y, Z
//  ula_sel      out  2       00 ADD, 01 SUB (other codes unused)
//  mux_x_sel    out  1       X input: 0 = external operand, 1 = Z feedback
//  done         out  1       one-cycle pulse, instruction retired
//  err          out  1       valid with done; 1 = illegal opcode was retired
// BEHAVIOUR
//  Reset: rst_n low at a rising edge -> state IDLE, shift counter 0, captured instr 0.
//   Outputs after that edge: Tx=Ty=Tz=HOLD, ula_sel=00, mux_x_sel=0, done=0, err=0, ready=1.
//   Reset wins over every other event. An in-flight op is abandoned and partial shifts stay applied.
//  States: IDLE -> EXEC -> DONE -> IDLE. SHRX/SHLX stay in EXEC for shamt cycles.
//   shamt=0 goes IDLE -> DONE directly.
//  Outputs are decoded (Moore) from the state, the captured opcode and the counter. Each output is HOLD/0 outside its cycles.
//  Accept: instr_valid & ready at an edge captures instr/shamt and leaves IDLE.
//   instr_valid while ready=0 is ignored, not queued. instr changes after accept have no effect.
//  Opcodes, outputs during EXEC (one cycle unless noted):
//   0000 CLR    Tx=Ty=Tz=RESET
//   0001 LDX    Tx=LOAD, mux_x_sel=0
//   0010 LDY    Ty=LOAD
//   0011 ADD    Tz=LOAD, ula_sel=00
//   0100 SUB    Tz=LOAD, ula_sel=01
//   0101 SHRX   Tx=SHIFTR for shamt consecutive cycles
//   0110 SHLX   Tx=SHIFTL for shamt consecutive cycles
//   0111 MOVZX  Tx=LOAD, mux_x_sel=1
//   1xxx        no EXEC cycle, IDLE -> DONE with err=1, all op codes HOLD
//  Timing: accept at end of cycle 0. EXEC occupies cycles 1..N (N=1, or shamt for shifts).
//   DONE (done=1, ready=0) is cycle N+1. IDLE with ready=1 is cycle N+2.
//   Single-cycle ops therefore issue at most one instruction every 3 cycles.
//  Counter: loaded with shamt on accept, decremented each EXEC cycle; EXEC exits when it reaches 0.
//   The counter never wraps.
//  err is 0 whenever done is 0. done is never asserted in two consecutive cycles.
// TESTING
//  1 rst_n=0 one edge with instr_valid=1 -> ready=1, Tx=Ty=Tz=000, done=0, no accept; release, idle 5 cycles -> outputs unchanged
//  2 LDX then LDY then ADD back-to-back (valid held) -> Tx=001 one cycle, done on the following cycle;
//    next instr accepted 3 cycles after the previous one; ADD cycle shows Tz=001, ula_sel=00
//  3 SHLX shamt=3 -> Tx=011 for exactly 3 cycles, done on 4th, ready on 5th; SHRX shamt=0 -> no SHIFT cycle, done cycle 1
//  4 instr=1010 -> Tx/Ty/Tz stay 000, done=1 and err=1 in cycle 1; next legal op reports err=0
//  5 SHRX shamt=3 with rst_n=0 in 2nd shift cycle -> next cycle Tx=000, ready=1, no done pulse
//  6 toggle instr/instr_valid during EXEC of MOVZX -> ignored; Tx=001 with mux_x_sel=1 exactly one cycle

Source files
------------

// File: rtl/register_sequencer_if.sv
// rtl/register_sequencer_if.sv - instruction handshake and register control bundle
// master issues instructions; slave (the sequencer) drives ready and the register op codes.
interface register_sequencer_if #(
  parameter int OPW    = 3,
  parameter int SHAMTW = 2
);
  logic [3:0]        instr;
  logic [SHAMTW-1:0] shamt;
  logic              instr_valid;
  logic              ready;
  logic [OPW-1:0]    Tx;
  logic [OPW-1:0]    Ty;
  logic [OPW-1:0]    Tz;
  logic [1:0]        ula_sel;
  logic              mux_x_sel;
  logic              done;
  logic              err;

  modport master (
    output instr, shamt, instr_valid,
    input  ready, Tx, Ty, Tz, ula_sel, mux_x_sel, done, err
  );

  modport slave (
    input  instr, shamt, instr_valid,
    output ready, Tx, Ty, Tz, ula_sel, mux_x_sel, done, err
  );
endinterface

// File: rtl/register_sequencer.sv
// rtl/register_sequencer.sv - sequences X/Y/Z register op codes per accepted instruction
// IDLE -> EXEC (1 or shamt cycles) -> DONE -> IDLE; all outputs are Moore-decoded.
module register_sequencer #(
  parameter int OPW    = 3,
  parameter int SHAMTW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  register_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OPW-1:0] OP_HOLD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LOAD   = OPW'(1);
  localparam logic [OPW-1:0] OP_SHIFTR = OPW'(2);
  localparam logic [OPW-1:0] OP_SHIFTL = OPW'(3);
  localparam logic [OPW-1:0] OP_RESET  = OPW'(4);

  localparam logic [3:0] I_CLR   = 4'b0000;
  localparam logic [3:0] I_LDX   = 4'b0001;
  localparam logic [3:0] I_LDY   = 4'b0010;
  localparam logic [3:0] I_ADD   = 4'b0011;
  localparam logic [3:0] I_SUB   = 4'b0100;
  localparam logic [3:0] I_SHRX  = 4'b0101;
  localparam logic [3:0] I_SHLX  = 4'b0110;
  localparam logic [3:0] I_MOVZX = 4'b0111;

  logic [1:0]        state;
  logic [SHAMTW-1:0] cnt;
  logic [3:0]        op;

  logic shift_in;
  logic shift_op;

  assign shift_in = (bus.instr == I_SHRX) || (bus.instr == I_SHLX);
  assign shift_op = (op == I_SHRX) || (op == I_SHLX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            op  <= bus.instr;
            cnt <= bus.shamt;
            // illegal opcodes and zero-length shifts have no EXEC cycle
            if (bus.instr[3] || (shift_in && (bus.shamt == '0)))
              state <= S_DONE;
            else
              state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != '0)
            cnt <= cnt - SHAMTW'(1);
          if (!shift_op || (cnt <= SHAMTW'(1)))
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Tx        = OP_HOLD;
    bus.Ty        = OP_HOLD;
    bus.Tz        = OP_HOLD;
    bus.ula_sel   = 2'b00;
    bus.mux_x_sel = 1'b0;
    if (state == S_EXEC) begin
      case (op)
        I_CLR: begin
          bus.Tx = OP_RESET;
          bus.Ty = OP_RESET;
          bus.Tz = OP_RESET;
        end
        I_LDX:  bus.Tx = OP_LOAD;
        I_LDY:  bus.Ty = OP_LOAD;
        I_ADD:  bus.Tz = OP_LOAD;
        I_SUB: begin
          bus.Tz      = OP_LOAD;
          bus.ula_sel = 2'b01;
        end
        I_SHRX: bus.Tx = OP_SHIFTR;
        I_SHLX: bus.Tx = OP_SHIFTL;
        I_MOVZX: begin
          bus.Tx        = OP_LOAD;
          bus.mux_x_sel = 1'b1;
        end
        default: bus.Tx = OP_HOLD;
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.done  = (state == S_DONE);
  assign bus.err   = (state == S_DONE) && op[3];

endmodule

// File: tb/tb_register_sequencer.sv
// tb/tb_register_sequencer.sv - scoreboard bench for register_sequencer
// Expected per-cycle output vectors are queued at issue and compared at each negedge.
module tb_register_sequencer;

  typedef logic [14:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  register_sequencer_if #(.OPW(3), .SHAMTW(2)) bus ();

  register_sequencer #(.OPW(3), .SHAMTW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t  exp_q[$];
  string tag_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic vec_t mk(input bit r, input logic [2:0] tx, input logic [2:0] ty,
                              input logic [2:0] tz, input logic [1:0] u, input bit m,
                              input bit d, input bit e);
    return {r, tx, ty, tz, u, m, d, e};
  endfunction

  function automatic vec_t idle_vec();
    return mk(1'b1, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t exec_vec(input logic [3:0] op);
    case (op)
      4'd0:    return mk(1'b0, 3'd4, 3'd4, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0);
      4'd1:    return mk(1'b0, 3'd1, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      4'd2:    return mk(1'b0, 3'd0, 3'd1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      4'd3:    return mk(1'b0, 3'd0, 3'd0, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0);
      4'd4:    return mk(1'b0, 3'd0, 3'd0, 3'd1, 2'd1, 1'b0, 1'b0, 1'b0);
      4'd5:    return mk(1'b0, 3'd2, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      4'd6:    return mk(1'b0, 3'd3, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      4'd7:    return mk(1'b0, 3'd1, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      default: return mk(1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endcase
  endfunction

  function automatic vec_t observed();
    return {bus.ready, bus.Tx, bus.Ty, bus.Tz, bus.ula_sel, bus.mux_x_sel, bus.done, bus.err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    vec_t  e;
    string t;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
    end else begin
      e = idle_vec();
      t = "idle";
    end
    check(t, 32'(observed()), 32'(e));
  endtask

  task automatic push(input vec_t v, input string t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [1:0] sh, input bit hold,
                        input bit mess, input string name);
    int n;
    bus.instr       = op;
    bus.shamt       = sh;
    bus.instr_valid = 1'b1;
    while (exp_q.size() > 0) tick();
    if (op[3])
      n = 0;
    else if (op == 4'd5 || op == 4'd6)
      n = int'(sh);
    else
      n = 1;
    for (int i = 0; i < n; i++) push(exec_vec(op), {name, ".exec"});
    push(mk(1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, op[3]), {name, ".done"});
    push(idle_vec(), {name, ".idle"});
    tick();
    while (exp_q.size() > 0) begin
      if (mess) begin
        bus.instr       = 4'($urandom);
        bus.instr_valid = 1'($urandom);
      end
      tick();
    end
    bus.instr_valid = hold;
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.instr       = 4'b0001;
    bus.shamt       = 2'd0;
    bus.instr_valid = 1'b1;
    rst_n           = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset", 32'(observed()), 32'(idle_vec()));
    rst_n           = 1'b1;
    bus.instr_valid = 1'b0;
    repeat (5) tick();

    run_op(4'd1, 2'd0, 1'b1, 1'b0, "ldx");
    run_op(4'd2, 2'd0, 1'b1, 1'b0, "ldy");
    run_op(4'd3, 2'd0, 1'b0, 1'b0, "add");
    run_op(4'd4, 2'd3, 1'b0, 1'b0, "sub");
    run_op(4'd0, 2'd0, 1'b0, 1'b0, "clr");

    run_op(4'd6, 2'd3, 1'b0, 1'b0, "shlx3");
    run_op(4'd5, 2'd0, 1'b0, 1'b0, "shrx0");
    run_op(4'd5, 2'd1, 1'b1, 1'b0, "shrx1");
    run_op(4'd6, 2'd2, 1'b0, 1'b0, "shlx2");

    run_op(4'b1010, 2'd0, 1'b0, 1'b0, "ill_a");
    run_op(4'd1, 2'd0, 1'b0, 1'b0, "ldx_post_ill");
    run_op(4'b1111, 2'd3, 1'b0, 1'b0, "ill_f");

    bus.instr       = 4'd5;
    bus.shamt       = 2'd3;
    bus.instr_valid = 1'b1;
    push(exec_vec(4'd5), "rst_mid.sh1");
    tick();
    bus.instr_valid = 1'b0;
    push(exec_vec(4'd5), "rst_mid.sh2");
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    run_op(4'd7, 2'd0, 1'b0, 1'b1, "movzx");
    bus.instr_valid = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
